// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS memory-access stage; registers Execute results, runs loads/stores on a req/ack bus.
// Latency: non-memory op 1 cycle to writeback; memory op 1 + (ack wait) cycles; timeout after DM_TIMEOUT req cycles.
// Backpressure: o_ex_ready is high only in IDLE, so Execute is stalled for the whole access and the RESP cycle.
//
// Ports:
//   i_clk, i_rst (async active-high)
//   i_ex_*  : Execute bundle (valid, ALU result/address, zero, branch target, store data, dest reg, control bits)
//   o_ex_ready : stage can accept
//   o_dm_*  / i_dm_* : data-memory request, write enable, address, wdata / rdata, ack
//   o_pc_src, o_branch_target : one-cycle branch decision to Fetch
//   o_wb_*  : one-cycle writeback bundle to Writeback
//   o_bus_err : one-cycle pulse on bus timeout or misaligned access
// Optional feature: define MEM_ALIGN_CHECK_EN to abort word accesses whose address bits [1:0] are nonzero.
module mem_access_stage #(
  parameter int unsigned DM_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ex_valid,
  output logic        o_ex_ready,
  input  logic [31:0] i_ex_alu_res,
  input  logic        i_ex_zero,
  input  logic [31:0] i_ex_branch_addr,
  input  logic [31:0] i_ex_store_data,
  input  logic [4:0]  i_ex_write_reg,
  input  logic        i_ex_mem_read,
  input  logic        i_ex_mem_write,
  input  logic        i_ex_branch,
  input  logic        i_ex_reg_write,
  input  logic        i_ex_mem_to_reg,
  output logic        o_dm_req,
  output logic        o_dm_we,
  output logic [31:0] o_dm_addr,
  output logic [31:0] o_dm_wdata,
  input  logic [31:0] i_dm_rdata,
  input  logic        i_dm_ack,
  output logic        o_pc_src,
  output logic [31:0] o_branch_target,
  output logic        o_wb_valid,
  output logic        o_wb_reg_write,
  output logic [4:0]  o_wb_write_reg,
  output logic [31:0] o_wb_data,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Counter value seen in the last allowed request cycle.
  localparam logic [7:0] LP_WAIT_LAST = 8'(DM_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_wait_cnt;
  logic        r_abort;
  logic [31:0] r_alu_res;
  logic        r_zero;
  logic [31:0] r_branch_addr;
  logic [31:0] r_store_data;
  logic [4:0]  r_write_reg;
  logic        r_mem_write;
  logic        r_branch;
  logic        r_reg_write;
  logic        r_mem_to_reg;
  logic [31:0] r_rdata;

  logic w_accept;
  logic w_timeout;
  logic w_is_mem;
  logic w_misalign;

  assign w_is_mem = i_ex_mem_read | i_ex_mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  // Address bits are checked as they are captured, so the fault goes straight to RESP.
  assign w_misalign = w_is_mem & (i_ex_alu_res[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_accept        = 1'b0;
    w_timeout       = 1'b0;
    o_ex_ready      = 1'b0;
    o_dm_req        = 1'b0;
    o_dm_we         = 1'b0;
    o_dm_addr       = 32'h0;
    o_dm_wdata      = 32'h0;
    o_pc_src        = 1'b0;
    o_branch_target = 32'h0;
    o_wb_valid      = 1'b0;
    o_wb_reg_write  = 1'b0;
    o_wb_write_reg  = 5'd0;
    o_wb_data       = 32'h0;
    o_bus_err       = 1'b0;
    case (r_state)
      IDLE: begin
        o_ex_ready = 1'b1;
        if (i_ex_valid) begin
          w_accept = 1'b1;
          if (w_is_mem && !w_misalign) w_next_state = ACCESS;
          else                         w_next_state = RESP;
        end
      end
      ACCESS: begin
        o_dm_req   = 1'b1;
        // mem_write wins when both read and write are set.
        o_dm_we    = r_mem_write;
        o_dm_addr  = r_alu_res;
        o_dm_wdata = r_store_data;
        if (i_dm_ack) begin
          w_next_state = RESP;
        end else if (r_wait_cnt == LP_WAIT_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = RESP;
        end
      end
      RESP: begin
        o_wb_valid      = 1'b1;
        o_wb_reg_write  = r_reg_write & ~r_abort;
        o_wb_write_reg  = r_write_reg;
        o_wb_data       = r_mem_to_reg ? r_rdata : r_alu_res;
        o_pc_src        = r_branch & r_zero;
        o_branch_target = r_branch_addr;
        o_bus_err       = r_abort;
        w_next_state    = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait_cnt    <= 8'd0;
      r_abort       <= 1'b0;
      r_alu_res     <= 32'h0;
      r_zero        <= 1'b0;
      r_branch_addr <= 32'h0;
      r_store_data  <= 32'h0;
      r_write_reg   <= 5'd0;
      r_mem_write   <= 1'b0;
      r_branch      <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_rdata       <= 32'h0;
    end else if (w_accept) begin
      r_wait_cnt    <= 8'd0;
      r_abort       <= w_misalign;
      r_alu_res     <= i_ex_alu_res;
      r_zero        <= i_ex_zero;
      r_branch_addr <= i_ex_branch_addr;
      r_store_data  <= i_ex_store_data;
      r_write_reg   <= i_ex_write_reg;
      r_mem_write   <= i_ex_mem_write;
      r_branch      <= i_ex_branch;
      r_reg_write   <= i_ex_reg_write;
      r_mem_to_reg  <= i_ex_mem_to_reg;
      // Stale load data must not leak into a later aborted access.
      r_rdata       <= 32'h0;
    end else if (r_state == ACCESS) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
      if (i_dm_ack) r_rdata <= i_dm_rdata;
      if (w_timeout) r_abort <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for mem_access_stage.
// Expected writeback bundles are queued at issue time and compared when o_wb_valid is seen.
// Memory responses are driven inline with a programmable ack latency.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_alu_res, ex_branch_addr, ex_store_data;
  logic        ex_zero;
  logic [4:0]  ex_write_reg;
  logic        ex_mem_read, ex_mem_write, ex_branch, ex_reg_write, ex_mem_to_reg;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_data;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_access_stage #(.DM_TIMEOUT(15)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ex_valid(ex_valid), .o_ex_ready(ex_ready),
    .i_ex_alu_res(ex_alu_res), .i_ex_zero(ex_zero),
    .i_ex_branch_addr(ex_branch_addr), .i_ex_store_data(ex_store_data),
    .i_ex_write_reg(ex_write_reg),
    .i_ex_mem_read(ex_mem_read), .i_ex_mem_write(ex_mem_write),
    .i_ex_branch(ex_branch), .i_ex_reg_write(ex_reg_write), .i_ex_mem_to_reg(ex_mem_to_reg),
    .o_dm_req(dm_req), .o_dm_we(dm_we), .o_dm_addr(dm_addr), .o_dm_wdata(dm_wdata),
    .i_dm_rdata(dm_rdata), .i_dm_ack(dm_ack),
    .o_pc_src(pc_src), .o_branch_target(branch_target),
    .o_wb_valid(wb_valid), .o_wb_reg_write(wb_reg_write),
    .o_wb_write_reg(wb_write_reg), .o_wb_data(wb_data), .o_bus_err(bus_err)
  );

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] data;
    logic        chk_data;
    logic        pc;
    logic [31:0] tgt;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_push = 0;
  int   n_wb = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic push(input logic rw, input logic [4:0] wr, input logic [31:0] data,
                      input logic cd, input logic pc, input logic [31:0] tgt, input logic err);
    exp_t e;
    e.rw = rw; e.wr = wr; e.data = data; e.chk_data = cd; e.pc = pc; e.tgt = tgt; e.err = err;
    sb_q.push_back(e);
    n_push++;
  endtask

  // Writeback monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        n_wb++;
        check("wb_reg_write", 32'(wb_reg_write), 32'(mon_e.rw));
        check("wb_write_reg", 32'(wb_write_reg), 32'(mon_e.wr));
        if (mon_e.chk_data) check("wb_data", wb_data, mon_e.data);
        check("pc_src", 32'(pc_src), 32'(mon_e.pc));
        check("branch_target", branch_target, mon_e.tgt);
        check("bus_err", 32'(bus_err), 32'(mon_e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] alu, input logic zero, input logic [31:0] baddr,
                       input logic [31:0] sdata, input logic [4:0] wreg, input logic mr,
                       input logic mw, input logic br, input logic rw, input logic m2r);
    int g;
    g = 0;
    while (ex_ready !== 1'b1 && g < 50) begin
      tick();
      g++;
    end
    if (g >= 50) check("ready_wait_timeout", 32'd0, 32'd1);
    ex_alu_res = alu; ex_zero = zero; ex_branch_addr = baddr; ex_store_data = sdata;
    ex_write_reg = wreg; ex_mem_read = mr; ex_mem_write = mw; ex_branch = br;
    ex_reg_write = rw; ex_mem_to_reg = m2r;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    // Scramble the inputs so only latched values can reach the outputs.
    ex_alu_res = $urandom; ex_branch_addr = $urandom; ex_store_data = $urandom;
    ex_zero = 1'b0; ex_branch = 1'b0; ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0;
    ex_write_reg = 5'($urandom);
  endtask

  // Serve one request: ack in the (lat+1)-th req cycle; lat < 0 never acks.
  task automatic mem_serve(input int lat, input logic [31:0] rd, input logic we_e,
                           input logic [31:0] addr_e, input logic [31:0] wd_e, output int cnt);
    logic bad_fields, bad_ready;
    cnt = 0; bad_fields = 1'b0; bad_ready = 1'b0;
    while (dm_req === 1'b1 && cnt < 100) begin
      cnt++;
      if (dm_we !== we_e || dm_addr !== addr_e || dm_wdata !== wd_e) bad_fields = 1'b1;
      if (ex_ready !== 1'b0) bad_ready = 1'b1;
      if (cnt == lat + 1) begin
        dm_ack = 1'b1;
        dm_rdata = rd;
      end
      tick();
      dm_ack = 1'b0;
      dm_rdata = $urandom;
    end
    check("dm_fields_stable", 32'(bad_fields), 32'd0);
    check("ex_ready_stalled", 32'(bad_ready), 32'd0);
  endtask

  int cnt;

  initial begin
    rst = 1'b1; ex_valid = 1'b0; dm_ack = 1'b0; dm_rdata = 32'h0;
    ex_alu_res = 32'h0; ex_zero = 1'b0; ex_branch_addr = 32'h0; ex_store_data = 32'h0;
    ex_write_reg = 5'd0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_branch = 1'b0;
    ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0;
    #12;
    check("rst_ex_ready", 32'(ex_ready), 32'd1);
    check("rst_dm_req", 32'(dm_req), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_pc_src", 32'(pc_src), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // ALU op: one-cycle writeback, ex_ready low for exactly one cycle.
    push(1'b1, 5'd5, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(32'h10, 1'b0, 32'h0, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("alu_wb_valid", 32'(wb_valid), 32'd1);
    check("alu_ready_low", 32'(ex_ready), 32'd0);
    tick();
    check("alu_ready_back", 32'(ex_ready), 32'd1);

    // Load, ack two cycles after req.
    push(1'b1, 5'd8, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(32'h100, 1'b0, 32'h0, 32'h55, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    mem_serve(2, 32'hDEADBEEF, 1'b0, 32'h100, 32'h55, cnt);
    check("load_req_cycles", 32'(cnt), 32'd3);
    check("load_req_dropped", 32'(dm_req), 32'd0);
    check("load_wb_valid", 32'(wb_valid), 32'd1);

    // Store, ack immediately, no register write.
    push(1'b0, 5'd3, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(32'h200, 1'b0, 32'h0, 32'h12345678, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_serve(0, 32'hCAFEF00D, 1'b1, 32'h200, 32'h12345678, cnt);
    check("store_req_cycles", 32'(cnt), 32'd1);

    // Read+write set is a store; reg_write still writes the ALU result.
    push(1'b1, 5'd9, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(32'h300, 1'b0, 32'h0, 32'hA5A5A5A5, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    mem_serve(1, 32'h11111111, 1'b1, 32'h300, 32'hA5A5A5A5, cnt);
    check("rw_store_req_cycles", 32'(cnt), 32'd2);

    // Branch taken, then not taken.
    push(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0);
    issue(32'h0, 1'b1, 32'h40, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("br_pc_src_pulse", 32'(pc_src), 32'd1);
    tick();
    check("br_pc_src_drop", 32'(pc_src), 32'd0);
    push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h80, 1'b0);
    issue(32'h4, 1'b0, 32'h80, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("br_nt_pc_src", 32'(pc_src), 32'd0);

    // Load with no ack: timeout after exactly 15 request cycles.
    push(1'b0, 5'd7, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(32'h104, 1'b0, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    mem_serve(-1, 32'h0, 1'b0, 32'h104, 32'h0, cnt);
    check("timeout_req_cycles", 32'(cnt), 32'd15);
    check("timeout_bus_err", 32'(bus_err), 32'd1);
    push(1'b1, 5'd2, 32'h77, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(32'h77, 1'b0, 32'h0, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("after_timeout_accept", 32'(wb_valid), 32'd1);
    tick();

    // Ack while idle is ignored.
    dm_ack = 1'b1;
    tick();
    tick();
    dm_ack = 1'b0;
    check("idle_ack_no_wb", 32'(wb_valid), 32'd0);
    check("idle_ack_no_req", 32'(dm_req), 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
    push(1'b0, 5'd4, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(32'h102, 1'b0, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("misalign_no_req", 32'(dm_req), 32'd0);
    check("misalign_bus_err", 32'(bus_err), 32'd1);
`else
    push(1'b1, 5'd4, 32'h0BADF00D, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(32'h102, 1'b0, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    mem_serve(0, 32'h0BADF00D, 1'b0, 32'h102, 32'h0, cnt);
    check("unaligned_req_cycles", 32'(cnt), 32'd1);
`endif

    // Reset in the middle of an access: request drops at once, no writeback.
    issue(32'h400, 1'b0, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("pre_rst_req", 32'(dm_req), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(dm_req), 32'd0);
    check("mid_rst_ready", 32'(ex_ready), 32'd1);
    check("mid_rst_wb", 32'(wb_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_wb", 32'(wb_valid), 32'd0);
    check("post_rst_req", 32'(dm_req), 32'd0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("wb_count", 32'(n_wb), 32'(n_push));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
